// File: rtl/decode.sv
// decode: MIPS ID stage with register file (WB bypass), control decode, load-use stall and bubble insertion
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_npc,
  input  logic        ex_mem_pc_src,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        id_stall,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex
);
  logic [31:0] regs [32];
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        is_r, is_lw, is_sw, is_beq, wr_en;
  logic [31:0] rs_data, rt_data;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [3:0]  ex;
  always_comb begin
    op       = if_id_instr[31:26];
    rs       = if_id_instr[25:21];
    rt       = if_id_instr[20:16];
    is_r     = op == 6'h00;
    is_lw    = op == 6'h23;
    is_sw    = op == 6'h2B;
    is_beq   = op == 6'h04;
    wb       = {is_r | is_lw, is_lw};
    m        = {is_beq, is_lw, is_sw};
    ex       = {is_r, is_r, is_beq, is_lw | is_sw};
    wr_en    = wb_reg_write && wb_write_reg != 5'd0;
    rs_data  = rs == 5'd0 ? 32'd0 : (wr_en && wb_write_reg == rs) ? wb_write_data : regs[rs];
    rt_data  = rt == 5'd0 ? 32'd0 : (wr_en && wb_write_reg == rt) ? wb_write_data : regs[rt];
    id_stall = id_ex_m[1] && id_ex_rt != 5'd0 &&
               (id_ex_rt == rs || (id_ex_rt == rt && (is_r || is_sw || is_beq)));
  end
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    else if (wr_en)
      regs[wb_write_reg] <= wb_write_data;
  end
  always_ff @(posedge clk) begin
    if (rst || ex_mem_pc_src || id_stall) begin
      id_ex_npc     <= 32'd0;
      id_ex_rs_data <= 32'd0;
      id_ex_rt_data <= 32'd0;
      id_ex_imm     <= 32'd0;
      id_ex_rs      <= 5'd0;
      id_ex_rt      <= 5'd0;
      id_ex_rd      <= 5'd0;
      id_ex_wb      <= 2'd0;
      id_ex_m       <= 3'd0;
      id_ex_ex      <= 4'd0;
    end else begin
      id_ex_npc     <= if_id_npc;
      id_ex_rs_data <= rs_data;
      id_ex_rt_data <= rt_data;
      id_ex_imm     <= {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      id_ex_rs      <= rs;
      id_ex_rt      <= rt;
      id_ex_rd      <= if_id_instr[15:11];
      id_ex_wb      <= wb;
      id_ex_m       <= m;
      id_ex_ex      <= ex;
    end
  end
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed plus randomized check of decode against a behavioural pipeline model
module tb_decode;
  logic        clk = 0, rst = 0, ex_mem_pc_src = 0, wb_reg_write = 0;
  logic [31:0] if_id_instr = 0, if_id_npc = 0, wb_write_data = 0;
  logic [4:0]  wb_write_reg = 0;
  logic        id_stall;
  logic [31:0] id_ex_npc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mreg [32];
  logic [31:0] e_npc, e_rsd, e_rtd, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [8:0]  e_ctl;
  bit valid = 0;
  decode dut (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .ex_mem_pc_src(ex_mem_pc_src), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .id_stall(id_stall), .id_ex_npc(id_ex_npc),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction
  function automatic logic [31:0] rd_reg(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wreg, input logic [31:0] wdata);
    if (idx == 0) return 0;
    if (we && wreg == idx) return wdata;
    return mreg[idx];
  endfunction
  task automatic step(input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
                      input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                      input logic r);
    logic stall, uses_rt;
    logic [4:0] s, t;
    rst = r; if_id_instr = instr; if_id_npc = npc; ex_mem_pc_src = pcsrc;
    wb_reg_write = we; wb_write_reg = wreg; wb_write_data = wdata;
    s = instr[25:21];
    t = instr[20:16];
    uses_rt = instr[31:26] inside {6'h00, 6'h2B, 6'h04};
    stall = valid && e_ctl[5] && e_rt != 0 && (e_rt == s || (uses_rt && e_rt == t));
    #1;
    if (valid) chk("stall", {31'd0, id_stall}, {31'd0, stall});
    @(posedge clk);
    #1;
    if (r) begin
      foreach (mreg[i]) mreg[i] = 0;
      {e_npc, e_rsd, e_rtd, e_imm, e_rs, e_rt, e_rd, e_ctl} = '0;
      valid = 1;
    end else if (pcsrc || stall) begin
      if (we && wreg != 0) mreg[wreg] = wdata;
      {e_npc, e_rsd, e_rtd, e_imm, e_rs, e_rt, e_rd, e_ctl} = '0;
    end else begin
      e_rsd = rd_reg(s, we, wreg, wdata);
      e_rtd = rd_reg(t, we, wreg, wdata);
      if (we && wreg != 0) mreg[wreg] = wdata;
      e_npc = npc;
      e_imm = 32'(signed'(instr[15:0]));
      e_rs = s; e_rt = t; e_rd = instr[15:11];
      e_ctl = ctl(instr[31:26]);
    end
    chk("npc", id_ex_npc, e_npc);
    chk("rs_data", id_ex_rs_data, e_rsd);
    chk("rt_data", id_ex_rt_data, e_rtd);
    chk("imm", id_ex_imm, e_imm);
    chk("rs", 32'(id_ex_rs), 32'(e_rs));
    chk("rt", 32'(id_ex_rt), 32'(e_rt));
    chk("rd", 32'(id_ex_rd), 32'(e_rd));
    chk("wb", 32'(id_ex_wb), 32'(e_ctl[8:7]));
    chk("m", 32'(id_ex_m), 32'(e_ctl[6:4]));
    chk("ex", 32'(id_ex_ex), 32'(e_ctl[3:0]));
  endtask
  initial begin
    logic [5:0] op;
    logic [31:0] ins;
    step(32'h8D090004, 32'h10, 0, 1, 5, 32'h1, 1);
    chk("rst_stall", {31'd0, id_stall}, 32'd0);
    step(32'h01095020, 4, 0, 0, 0, 0, 0);
    chk("read_r8_zero", id_ex_rs_data, 32'd0);
    step(0, 0, 0, 1, 8, 32'h12345678, 0);
    step(0, 0, 0, 1, 9, 32'h00000010, 0);
    step(32'h01095020, 4, 0, 0, 0, 0, 0);
    chk("add_rs", id_ex_rs_data, 32'h12345678);
    chk("add_ex", 32'(id_ex_ex), 32'b1100);
    step(32'h01095020, 4, 0, 1, 9, 32'h00000077, 0);
    chk("bypass_rt", id_ex_rt_data, 32'h77);
    step(32'h8D090004, 8, 0, 0, 0, 0, 0);
    chk("lw_m", 32'(id_ex_m), 32'b010);
    step(32'h01295020, 12, 0, 0, 0, 0, 0);
    chk("lu_bubble_wb", 32'(id_ex_wb), 32'd0);
    step(32'h01295020, 12, 0, 0, 0, 0, 0);
    chk("lu_resume_npc", id_ex_npc, 32'd12);
    step(32'h8D000004, 16, 0, 0, 0, 0, 0);
    step(32'h00005020, 20, 0, 0, 0, 0, 0);
    step(32'h1109FFFF, 24, 0, 0, 0, 0, 0);
    chk("beq_imm", id_ex_imm, 32'hFFFFFFFF);
    step(32'h01095020, 28, 1, 1, 3, 32'hAA, 0);
    step(32'h00605020, 32, 0, 0, 0, 0, 0);
    chk("flush_wb_r3", id_ex_rs_data, 32'hAA);
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0);
    step(32'h00005020, 36, 0, 0, 0, 0, 0);
    chk("r0_zero", id_ex_rs_data, 32'd0);
    step(32'hFC00FFFF, 40, 0, 0, 0, 0, 0);
    step(32'h8D090004, 44, 0, 0, 0, 0, 0);
    step(32'h01295020, 48, 0, 1, 4, 32'h5, 1);
    step(32'h01295020, 48, 0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1, 2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        default: op = 6'($urandom);
      endcase
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      step(ins, $urandom, $urandom_range(0, 7) == 0, 1'($urandom), 5'($urandom_range(0, 4)),
           $urandom, $urandom_range(0, 49) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
